slave_rx: RTL and testbench
===========================

SLAVE_RX -- requirements
Module: slave_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the buffer entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port s_data, input, WIDTH bits: upstream data.
REQ-006 The block SHALL have port s_valid, input, 1 bit: upstream data valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: block can accept a beat; it drives the upstream ready.
REQ-008 The block SHALL have port out_data, output, WIDTH bits: head-of-buffer data.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a buffered beat.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head beat.
REQ-011 The block SHALL have port fill, output, clog2(DEPTH)+1 bits: the current number of buffered entries.
REQ-012 The block SHALL have port beat_cnt, output, 16 bits: accepted beats since reset, wrapping.
REQ-013 The block SHALL have port seq_err, output, 1 bit: one-cycle pulse on a sequence mismatch.
REQ-014 The block SHALL have port err_cnt, output, 8 bits: sequence mismatches since reset, saturating at 255.

Function
REQ-015 An upstream beat SHALL be accepted exactly on a rising edge where s_valid and s_ready are both 1.
REQ-016 s_ready SHALL be 1 iff fill is less than DEPTH, decoded from registers only, with no path from s_valid or out_ready.
REQ-017 A pop SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-018 out_valid SHALL be 1 iff fill is not 0; out_data SHALL be the oldest buffered entry.
REQ-019 Latency: an accepted beat SHALL appear on out_data no earlier than the cycle after acceptance; there is no combinational bypass, even when the buffer is empty.
REQ-020 On a simultaneous push and pop, fill SHALL be unchanged and order SHALL be preserved.
REQ-021 Push-only SHALL increment fill by 1; pop-only SHALL decrement fill by 1.
REQ-022 When full, s_ready=0 and no write SHALL occur; when empty, no pop SHALL occur, and out_ready is ignored.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 While s_valid=1 and s_ready=0, the block SHALL NOT accept a beat, SHALL NOT count it and SHALL NOT check it.
REQ-025 beat_cnt SHALL increment by 1 on every accepted beat and SHALL wrap from 65535 to 0.
REQ-026 Checker state SHALL be IDLE, then ARMED, with an expected register of WIDTH bits.
REQ-027 In IDLE, the first accepted beat SHALL load expected with s_data+1 mod 2^WIDTH, SHALL move the checker to ARMED and SHALL raise no error.
REQ-028 In ARMED, each accepted beat SHALL be compared with expected, and expected SHALL be reloaded with s_data+1 mod 2^WIDTH (resynchronise on the received value).
REQ-029 On a mismatch, seq_err SHALL be 1 for the cycle after acceptance and err_cnt SHALL increment unless it is already 255.
REQ-030 Wrap of the expected value from 2^WIDTH-1 to 0 SHALL count as in-sequence.

Reset
REQ-031 While rst_n=0: fill=0, pointers=0, s_ready=0, out_valid=0, out_data=0, beat_cnt=0, err_cnt=0, seq_err=0, checker=IDLE, expected=0.
REQ-032 Reset assertion SHALL take effect immediately, including mid-transfer; buffered beats SHALL be discarded.
REQ-033 After deassertion, s_ready SHALL be 1 from the first rising edge onward.
REQ-034 Buffer storage SHALL NOT need a reset, but out_data SHALL read 0 whenever out_valid=0.

Configuration
REQ-035 Macro SLAVE_RX_SEQ_CHECK_EN SHALL control the sequence checker.
REQ-036 With SLAVE_RX_SEQ_CHECK_EN defined, REQ-026..REQ-030 SHALL apply.
REQ-037 Without SLAVE_RX_SEQ_CHECK_EN, no checker logic SHALL be built: seq_err=0 and err_cnt=0 constantly; all ports remain present and buffering is unchanged.

Verification
REQ-038 Reset, then upstream sends 0,1,2,... with out_ready=1 -> out_data shows 0,1,2 each one cycle after acceptance; err_cnt=0; beat_cnt=N after N beats.
REQ-039 DEPTH=4, out_ready=0, s_valid=1 for 6 cycles -> 4 accepted, fill=4, s_ready=0; then out_ready=1 -> pops 0..3 in order and s_ready returns to 1.
REQ-040 With the macro defined, send 5,6,9,10 -> single seq_err pulse after 9, err_cnt=1, no error on 10.
REQ-041 WIDTH=8, send 254,255,0,1 -> err_cnt stays 0.
REQ-042 Assert rst_n=0 with fill=3 mid-stream -> all outputs zero immediately; after release, the first beat 7 raises no error (IDLE re-arm).
REQ-043 Without the macro, send 5,9 -> seq_err never 1, err_cnt=0, and data path identical to REQ-038.

Source files
------------

// File: rtl/slave_rx.sv
// slave_rx: receive buffer with an optional upstream sequence checker.
//
// Upstream beats land in a DEPTH-entry FIFO. The head entry drives out_data/out_valid.
// s_ready is decoded from registered state only.
// An accepted beat is visible on out_data one cycle after acceptance at the earliest.
//
// Optional feature: define SLAVE_RX_SEQ_CHECK_EN to build the sequence checker.
// Each accepted beat is compared against (previous beat + 1).
// Without the macro, seq_err and err_cnt are tied to zero.
module slave_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [15:0]                beat_cnt,
    output logic                       seq_err,
    output logic [7:0]                 err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    // Buffer state
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    // Held low through reset so s_ready stays 0 until the first edge after release
    logic             run_q;

    logic push, pop;

    assign s_ready   = run_q && (fill_q != FULL);
    assign out_valid = (fill_q != '0);
    assign push      = s_valid && s_ready;
    assign pop       = out_valid && out_ready;
    // Storage is not reset, so mask it whenever there is no valid head entry
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill      = fill_q;
    assign beat_cnt  = beat_cnt_q;

    // Next-state for pointers, occupancy and beat counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        beat_cnt_d = beat_cnt_q;
        if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Control registers; reset discards any buffered beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            beat_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            beat_cnt_q <= beat_cnt_d;
            run_q      <= 1'b1;
        end
    end

    // Buffer write; storage contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

`ifdef SLAVE_RX_SEQ_CHECK_EN
    localparam logic [0:0] CHK_IDLE  = 1'b0;
    localparam logic [0:0] CHK_ARMED = 1'b1;

    logic [0:0]       chk_state_q, chk_state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             seq_err_q, seq_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    // Checker: the first beat arms it; every later beat is compared, then expected resyncs
    always_comb begin
        chk_state_d = chk_state_q;
        exp_d       = exp_q;
        seq_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (push) begin
            exp_d       = s_data + WIDTH'(1);
            chk_state_d = CHK_ARMED;
            if ((chk_state_q == CHK_ARMED) && (s_data != exp_q)) begin
                seq_err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    // Checker registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_state_q <= CHK_IDLE;
            exp_q       <= '0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            chk_state_q <= chk_state_d;
            exp_q       <= exp_d;
            seq_err_q   <= seq_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign seq_err = seq_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign seq_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_slave_rx.sv
// Directed bench for slave_rx (WIDTH=8, DEPTH=4). Expectations follow the
// SLAVE_RX_SEQ_CHECK_EN setting of the build.
module tb_slave_rx;

`ifdef SLAVE_RX_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fill;
    logic [15:0] beat_cnt;
    logic       seq_err;
    logic [7:0] err_cnt;

    int n_tot = 0;
    int n_bad = 0;

    slave_rx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fill(fill), .beat_cnt(beat_cnt), .seq_err(seq_err), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, release, then one edge to bring s_ready up
    task automatic do_reset();
        s_valid   = 1'b0;
        out_ready = 1'b0;
        s_data    = '0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Push one beat with out_ready=1; head must show it right after the edge
    task automatic send(input logic [7:0] d, input logic exp_err, input string tag);
        out_ready = 1'b1;
        s_data    = d;
        s_valid   = 1'b1;
        step();
        s_valid = 1'b0;
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_err"}, seq_err, exp_err & CHK);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; out_ready = 1'b0; s_data = '0;
        #2;
        // Reset state
        chk("rst_fill", fill, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_beats", beat_cnt, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_seqerr", seq_err, 0);
        do_reset();
        chk("post_rst_sready", s_ready, 1);

        // Streaming 0..5 with out_ready=1
        for (int i = 0; i < 6; i++) send(8'(i), 1'b0, "stream");
        chk("stream_fill", fill, 1);
        chk("stream_beats", beat_cnt, 6);
        step();
        chk("stream_drain_fill", fill, 0);
        chk("stream_drain_ovalid", out_valid, 0);
        chk("stream_drain_odata", out_data, 0);
        chk("stream_errcnt", err_cnt, 0);

        // Fill to full; refused beats carry out-of-sequence data
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_data  = (i < 4) ? 8'(10 + i) : 8'd99;
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        chk("full_fill", fill, 4);
        chk("full_sready", s_ready, 0);
        chk("full_beats", beat_cnt, 4);
        chk("full_head", out_data, 10);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", out_data, 32'(10 + k));
            step();
            chk("drain_sready", s_ready, 1);
        end
        chk("drain_fill", fill, 0);
        chk("drain_ovalid", out_valid, 0);
        send(8'd14, 1'b0, "after_full");
        chk("after_full_errcnt", err_cnt, 0);

        // Sequence break 5,6,9,10
        do_reset();
        send(8'd5, 1'b0, "seq5");
        send(8'd6, 1'b0, "seq6");
        send(8'd9, 1'b1, "seq9");
        chk("seq9_errcnt", err_cnt, CHK ? 1 : 0);
        send(8'd10, 1'b0, "seq10");
        chk("seq_errcnt", err_cnt, CHK ? 1 : 0);
        chk("seq_beats", beat_cnt, 4);

        // Expected value wraps 255 -> 0
        do_reset();
        send(8'd254, 1'b0, "wrap254");
        send(8'd255, 1'b0, "wrap255");
        send(8'd0, 1'b0, "wrap0");
        send(8'd1, 1'b0, "wrap1");
        chk("wrap_errcnt", err_cnt, 0);

        // Reset mid-stream with three entries buffered
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data = 8'(20 + i); s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        chk("mid_fill", fill, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_fill", fill, 0);
        chk("mid_rst_ovalid", out_valid, 0);
        chk("mid_rst_odata", out_data, 0);
        chk("mid_rst_sready", s_ready, 0);
        chk("mid_rst_beats", beat_cnt, 0);
        do_reset();
        send(8'd7, 1'b0, "rearm7");
        chk("rearm_errcnt", err_cnt, 0);
        send(8'd9, 1'b1, "rearm9");
        chk("rearm9_errcnt", err_cnt, CHK ? 1 : 0);

        // Error counter saturation: 300 zeros give 299 mismatches
        do_reset();
        out_ready = 1'b1;
        s_data    = 8'd0;
        s_valid   = 1'b1;
        for (int i = 0; i < 300; i++) step();
        s_valid = 1'b0;
        chk("sat_errcnt", err_cnt, CHK ? 255 : 0);
        chk("sat_beats", beat_cnt, 300);
        chk("sat_fill", fill, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
